regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter AWIDTH, default 5, meaning register address width; depth is 2**AWIDTH.
REQ-002 SHALL have parameter DWIDTH, default 32, meaning register data width.
REQ-003 SHALL have parameter NREAD, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have port clk  input  1  meaning sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port raddr  input  NREAD*AWIDTH  meaning packed read addresses; port i uses bits [i*AWIDTH +: AWIDTH].
REQ-007 SHALL have port rdata  output  NREAD*DWIDTH  meaning packed read data, same packing as raddr.
REQ-008 SHALL have port rbusy  output  NREAD  meaning scoreboard busy bit of each addressed register.
REQ-009 SHALL have ports wen_a / waddr_a / wdata_a  input  1 / AWIDTH / DWIDTH  meaning ALU write port.
REQ-010 SHALL have ports wen_b / waddr_b / wdata_b  input  1 / AWIDTH / DWIDTH  meaning load-return write port.
REQ-011 SHALL have ports mark_en / mark_addr  input  1 / AWIDTH  meaning set busy on the destination of an issued load.
REQ-012 SHALL have port werr  output  1  meaning registered one-cycle pulse flagging a rejected port-A write.
REQ-013 SHALL have port busy_cnt  output  AWIDTH+1  meaning registered count of busy registers.

Function
REQ-014 Register 0 SHALL always read 0, ignore all writes, and never become busy (mark to 0 ignored).
REQ-015 Reads SHALL be combinational, zero-latency, independent per port; writes SHALL take effect at the next rising edge.
REQ-016 Port-B write SHALL store wdata_b and clear the busy bit of waddr_b at the edge.
REQ-017 Port-A write to a non-busy register SHALL store wdata_a; busy state unchanged.
REQ-018 Port-A write to a busy register SHALL be discarded and SHALL assert werr for exactly the following cycle.
REQ-019 Both ports writing the same non-zero address in one cycle SHALL store wdata_b; port A discarded, werr not asserted.
REQ-020 mark_en SHALL set busy of mark_addr at the edge; mark and port-B clear on the same address same cycle SHALL leave busy set (mark wins), data still written.
REQ-021 mark_en to an already-busy register SHALL leave it busy with no error.
REQ-022 busy_cnt SHALL equal the population count of busy bits after each edge; never exceeds 2**AWIDTH-1.
REQ-023 rbusy[i] SHALL reflect the current busy bit of raddr port i (subject to REQ-027).

Reset
REQ-024 With rst high at a rising edge, all registers SHALL become 0, all busy bits 0, werr 0, busy_cnt 0.
REQ-025 Reset SHALL override any simultaneous write or mark in that cycle; rst asserted mid-sequence discards pending state.
REQ-026 Outputs rdata SHALL read 0 and rbusy 0 in the cycle after reset.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, a read of an address accepted for write this cycle SHALL return the winning write data (B over A, never for register 0) and rbusy SHALL show 0 if port B clears it this cycle without a same-cycle mark.
REQ-028 Without REGFILE_BYPASS_EN, reads SHALL return stored register contents and stored busy bits only; new values visible from the next cycle.

Verification
REQ-029 Reset, then wen_a=1 waddr_a=3 wdata_a=0xDEADBEEF; next cycle raddr port0=3 -> rdata=0xDEADBEEF, rbusy=0, werr=0.
REQ-030 mark_en addr 5; next cycle wen_a addr 5 data 0x11 -> werr=1 one cycle, reg5 unchanged, busy_cnt=1.
REQ-031 Reg5 busy; wen_b addr 5 data 0x22 while reading 5 -> BYPASS_EN: rdata=0x22, rbusy=0 same cycle; without: old data, rbusy=1, then 0x22/0 next cycle; busy_cnt 1->0.
REQ-032 wen_a addr 7 data 0xAA and wen_b addr 7 data 0xBB same cycle -> reg7=0xBB, werr=0.
REQ-033 wen_a addr 0 data 0xFF plus mark_en addr 0 -> reads of 0 return 0, rbusy=0, busy_cnt=0.
REQ-034 Mark regs 1,2,3, assert rst with wen_b addr 1 same cycle -> all regs 0, busy_cnt=0, werr=0 next cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with load scoreboard: NREAD combinational read ports, ALU write port A,
// load-return write port B, busy tracking. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_sb #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32,
    parameter int NREAD  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREAD*AWIDTH-1:0]   raddr,
    output logic [NREAD*DWIDTH-1:0]   rdata,
    output logic [NREAD-1:0]          rbusy,
    input  logic                      wen_a,
    input  logic [AWIDTH-1:0]         waddr_a,
    input  logic [DWIDTH-1:0]         wdata_a,
    input  logic                      wen_b,
    input  logic [AWIDTH-1:0]         waddr_b,
    input  logic [DWIDTH-1:0]         wdata_b,
    input  logic                      mark_en,
    input  logic [AWIDTH-1:0]         mark_addr,
    output logic                      werr,
    output logic [AWIDTH:0]           busy_cnt
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [AWIDTH:0]   cnt_nxt;
    logic              b_wr;
    logic              a_hit_b;
    logic              a_wr;
    logic              a_rej;

    // Port B owns any address it shares with port A; such an A write is dropped silently.
    always_comb begin
        b_wr    = wen_b && (waddr_b != '0);
        a_hit_b = b_wr && (waddr_a == waddr_b);
        a_wr    = wen_a && (waddr_a != '0) && !busy[waddr_a] && !a_hit_b;
        a_rej   = wen_a && (waddr_a != '0) &&  busy[waddr_a] && !a_hit_b;
    end

    // Mark is applied after the clear so a same-address mark keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (b_wr)
            busy_nxt[waddr_b] = 1'b0;
        if (mark_en)
            busy_nxt[mark_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + {{AWIDTH{1'b0}}, busy_nxt[AWIDTH'(i)]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[AWIDTH'(i)] <= '0;
            busy     <= '0;
            werr     <= 1'b0;
            busy_cnt <= '0;
        end else begin
            if (a_wr)
                mem[waddr_a] <= wdata_a;
            if (b_wr)
                mem[waddr_b] <= wdata_b;
            busy     <= busy_nxt;
            werr     <= a_rej;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AWIDTH-1:0] ra;
        logic [DWIDTH-1:0] rd;
        logic              rb;

        assign ra = raddr[p*AWIDTH +: AWIDTH];

        always_comb begin
            rd = mem[ra];
            rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
            if (b_wr && (waddr_b == ra)) begin
                rd = wdata_b;
                if (!(mark_en && (mark_addr == ra)))
                    rb = 1'b0;
            end else if (a_wr && (waddr_a == ra)) begin
                rd = wdata_a;
            end
`endif
            if (ra == '0) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign rdata[p*DWIDTH +: DWIDTH] = rd;
        assign rbusy[p]                  = rb;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic against
// a rule-level model; honours REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;

    logic             clk;
    logic             rst;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             wen_a, wen_b, mark_en;
    logic [AW-1:0]    waddr_a, waddr_b, mark_addr;
    logic [DW-1:0]    wdata_a, wdata_b;
    logic             werr;
    logic [AW:0]      busy_cnt;

    regfile_sb #(.AWIDTH(AW), .DWIDTH(DW), .NREAD(NR)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen_a(wen_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
        .wen_b(wen_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
        .mark_en(mark_en), .mark_addr(mark_addr),
        .werr(werr), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] m_reg [32];
    bit            m_busy [32];
    bit            m_werr;
    int            checks = 0;
    int            passes = 0;

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wen_b && waddr_b == a) return wdata_b;
        if (wen_a && waddr_a == a && !m_busy[a]) return wdata_a;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_rb(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wen_b && waddr_b == a && !(mark_en && mark_addr == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    // Applies the architectural rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit b_same;
        bit a_busy;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
            m_werr = 1'b0;
        end else begin
            b_same = wen_b && waddr_b == waddr_a && waddr_a != 0;
            a_busy = m_busy[waddr_a];
            m_werr = wen_a && waddr_a != 0 && a_busy && !b_same;
            if (wen_a && waddr_a != 0 && !a_busy && !b_same) m_reg[waddr_a] = wdata_a;
            if (wen_b && waddr_b != 0) begin
                m_reg[waddr_b]  = wdata_b;
                m_busy[waddr_b] = 1'b0;
            end
            if (mark_en && mark_addr != 0) m_busy[mark_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wen_a = 1'b0; wen_b = 1'b0; mark_en = 1'b0;
        waddr_a = '0; waddr_b = '0; mark_addr = '0;
        wdata_a = '0; wdata_b = '0; raddr = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; wen_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h1234; mark_en = 1'b1; mark_addr = 5'd4;
        tick();
        tick();
        idle();
        raddr = {5'd4, 5'd9};
        #1;
        checks++;
        if (busy_cnt !== 0) $display("FAIL reset_cnt got=%0d exp=0", busy_cnt); else passes++;
        checks++;
        if (werr !== 1'b0) $display("FAIL reset_werr got=%b exp=0", werr); else passes++;
        checks++;
        if (rdata !== '0) $display("FAIL reset_rdata got=%h exp=0", rdata); else passes++;
        checks++;
        if (rbusy !== '0) $display("FAIL reset_rbusy got=%b exp=0", rbusy); else passes++;
    endtask

    task automatic test_alu_write();
        idle();
        wen_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hDEADBEEF;
        tick();
        idle();
        raddr = {5'd0, 5'd3};
        #1;
        checks++;
        if (rdata[DW-1:0] !== 32'hDEADBEEF) $display("FAIL alu_rdata got=%h exp=deadbeef", rdata[DW-1:0]); else passes++;
        checks++;
        if (rbusy[0] !== 1'b0) $display("FAIL alu_rbusy got=%b exp=0", rbusy[0]); else passes++;
        checks++;
        if (werr !== 1'b0) $display("FAIL alu_werr got=%b exp=0", werr); else passes++;
    endtask

    task automatic test_busy_reject();
        logic [DW-1:0] old;
        old = m_reg[5];
        idle();
        mark_en = 1'b1; mark_addr = 5'd5;
        tick();
        idle();
        wen_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h11;
        tick();
        checks++;
        if (werr !== 1'b1) $display("FAIL rej_werr got=%b exp=1", werr); else passes++;
        checks++;
        if (busy_cnt !== 1) $display("FAIL rej_cnt got=%0d exp=1", busy_cnt); else passes++;
        idle();
        raddr = {5'd5, 5'd5};
        #1;
        checks++;
        if (rdata[DW-1:0] !== old) $display("FAIL rej_data got=%h exp=%h", rdata[DW-1:0], old); else passes++;
        checks++;
        if (rbusy !== 2'b11) $display("FAIL rej_rbusy got=%b exp=11", rbusy); else passes++;
        tick();
        checks++;
        if (werr !== 1'b0) $display("FAIL rej_pulse got=%b exp=0", werr); else passes++;
    endtask

    task automatic test_load_return();
        logic [DW-1:0] old;
        logic [DW-1:0] exp_d;
        logic          exp_b;
        old = m_reg[5];
        idle();
        wen_b = 1'b1; waddr_b = 5'd5; wdata_b = 32'h22; raddr = {5'd0, 5'd5};
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'h22; exp_b = 1'b0;
`else
        exp_d = old; exp_b = 1'b1;
`endif
        #1;
        checks++;
        if (rdata[DW-1:0] !== exp_d) $display("FAIL ldret_same_data got=%h exp=%h", rdata[DW-1:0], exp_d); else passes++;
        checks++;
        if (rbusy[0] !== exp_b) $display("FAIL ldret_same_busy got=%b exp=%b", rbusy[0], exp_b); else passes++;
        tick();
        checks++;
        if (busy_cnt !== 0) $display("FAIL ldret_cnt got=%0d exp=0", busy_cnt); else passes++;
        idle();
        raddr = {5'd0, 5'd5};
        #1;
        checks++;
        if (rdata[DW-1:0] !== 32'h22) $display("FAIL ldret_next_data got=%h exp=22", rdata[DW-1:0]); else passes++;
        checks++;
        if (rbusy[0] !== 1'b0) $display("FAIL ldret_next_busy got=%b exp=0", rbusy[0]); else passes++;
    endtask

    task automatic test_same_addr();
        idle();
        wen_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'hAA;
        wen_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'hBB;
        tick();
        checks++;
        if (werr !== 1'b0) $display("FAIL same_werr got=%b exp=0", werr); else passes++;
        idle();
        mark_en = 1'b1; mark_addr = 5'd9;
        raddr = {5'd0, 5'd7};
        #1;
        checks++;
        if (rdata[DW-1:0] !== 32'hBB) $display("FAIL same_data got=%h exp=bb", rdata[DW-1:0]); else passes++;
        tick();
        // A targets a busy register but B hits it too: B wins, no error, busy cleared
        idle();
        wen_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'hCC;
        wen_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'hDD;
        tick();
        idle();
        raddr = {5'd9, 5'd0};
        #1;
        checks++;
        if (werr !== 1'b0) $display("FAIL same_busy_werr got=%b exp=0", werr); else passes++;
        checks++;
        if (rdata[2*DW-1:DW] !== 32'hDD) $display("FAIL same_busy_data got=%h exp=dd", rdata[2*DW-1:DW]); else passes++;
        checks++;
        if (busy_cnt !== 0) $display("FAIL same_busy_cnt got=%0d exp=0", busy_cnt); else passes++;
    endtask

    task automatic test_mark_vs_clear();
        idle();
        mark_en = 1'b1; mark_addr = 5'd4;
        tick();
        tick();
        checks++;
        if (busy_cnt !== 1 || werr !== 1'b0) $display("FAIL remark got_cnt=%0d got_werr=%b exp=1/0", busy_cnt, werr); else passes++;
        idle();
        mark_en = 1'b1; mark_addr = 5'd4; wen_b = 1'b1; waddr_b = 5'd4; wdata_b = 32'h44;
        tick();
        idle();
        raddr = {5'd4, 5'd4};
        #1;
        checks++;
        if (rbusy !== 2'b11) $display("FAIL mark_wins_busy got=%b exp=11", rbusy); else passes++;
        checks++;
        if (rdata !== {32'h44, 32'h44}) $display("FAIL mark_wins_data got=%h exp=44", rdata); else passes++;
        checks++;
        if (busy_cnt !== 1) $display("FAIL mark_wins_cnt got=%0d exp=1", busy_cnt); else passes++;
        wen_b = 1'b1; waddr_b = 5'd4; wdata_b = 32'h45;
        tick();
        idle();
    endtask

    task automatic test_reg0();
        idle();
        wen_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFF;
        mark_en = 1'b1; mark_addr = 5'd0;
        tick();
        idle();
        wen_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'hFF;
        tick();
        idle();
        raddr = {5'd0, 5'd0};
        #1;
        checks++;
        if (rdata !== '0) $display("FAIL reg0_data got=%h exp=0", rdata); else passes++;
        checks++;
        if (rbusy !== '0) $display("FAIL reg0_busy got=%b exp=0", rbusy); else passes++;
        checks++;
        if (busy_cnt !== 0) $display("FAIL reg0_cnt got=%0d exp=0", busy_cnt); else passes++;
    endtask

    task automatic test_reset_midseq();
        for (int i = 1; i <= 3; i++) begin
            idle();
            mark_en = 1'b1; mark_addr = AW'(i);
            tick();
        end
        checks++;
        if (busy_cnt !== 3) $display("FAIL midrst_pre_cnt got=%0d exp=3", busy_cnt); else passes++;
        idle();
        wen_a = 1'b1; waddr_a = 5'd2; wdata_a = 32'h77;
        tick();
        idle();
        rst = 1'b1; wen_b = 1'b1; waddr_b = 5'd1; wdata_b = 32'h99;
        tick();
        idle();
        raddr = {5'd3, 5'd1};
        #1;
        checks++;
        if (busy_cnt !== 0) $display("FAIL midrst_cnt got=%0d exp=0", busy_cnt); else passes++;
        checks++;
        if (werr !== 1'b0) $display("FAIL midrst_werr got=%b exp=0", werr); else passes++;
        checks++;
        if (rdata !== '0 || rbusy !== '0) $display("FAIL midrst_read got=%h/%b exp=0/0", rdata, rbusy); else passes++;
    endtask

    task automatic test_random();
        logic [AW-1:0] ra [NR];
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 80) == 0);
            wen_a     = $urandom_range(0, 1) == 1;
            waddr_a   = AW'($urandom_range(0, 7));
            wdata_a   = $urandom;
            wen_b     = $urandom_range(0, 2) == 0;
            waddr_b   = AW'($urandom_range(0, 7));
            wdata_b   = $urandom;
            mark_en   = $urandom_range(0, 2) == 0;
            mark_addr = AW'($urandom_range(0, 7));
            for (int p = 0; p < NR; p++) begin
                ra[p] = AW'($urandom_range(0, 7));
                raddr[p*AW +: AW] = ra[p];
            end
            #1;
            for (int p = 0; p < NR; p++) begin
                checks++;
                if (rdata[p*DW +: DW] !== exp_rd(ra[p]))
                    $display("FAIL rnd_rdata%0d it=%0d addr=%0d got=%h exp=%h", p, n, ra[p], rdata[p*DW +: DW], exp_rd(ra[p]));
                else passes++;
                checks++;
                if (rbusy[p] !== exp_rb(ra[p]))
                    $display("FAIL rnd_rbusy%0d it=%0d addr=%0d got=%b exp=%b", p, n, ra[p], rbusy[p], exp_rb(ra[p]));
                else passes++;
            end
            tick();
            checks++;
            if (werr !== m_werr) $display("FAIL rnd_werr it=%0d got=%b exp=%b", n, werr, m_werr); else passes++;
            checks++;
            if (busy_cnt !== (AW+1)'(m_count())) $display("FAIL rnd_cnt it=%0d got=%0d exp=%0d", n, busy_cnt, m_count()); else passes++;
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_write();
        test_busy_reject();
        test_load_return();
        test_same_addr();
        test_mark_vs_clear();
        test_reg0();
        test_reset_midseq();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
